// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial bit-sequence detector
// Run-time loadable pattern, valid qualifier, overlap mode, saturating match counter.
module seq_detector_param #(
    parameter int             LEN           = 4,
    parameter int             COUNT_W       = 8,
    parameter logic [LEN-1:0] RESET_PATTERN = LEN'(4'b1011)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i,
    input  logic               i_valid,
    input  logic               cfg_load,
    input  logic [LEN-1:0]     cfg_pattern,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               o,
    output logic [COUNT_W-1:0] match_cnt,
    output logic               cnt_sat
);

    localparam int FILL_W = (LEN > 2) ? $clog2(LEN) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    logic [LEN-2:0]     hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [LEN-1:0]     pattern_q, pattern_d;
    logic               overlap_q, overlap_d;
    logic               o_q, o_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic [LEN-1:0]     word;
    logic               hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= RESET_PATTERN;
            overlap_q <= 1'b1;
            o_q       <= 1'b0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            overlap_q <= overlap_d;
            o_q       <= o_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
        end
    end

    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        overlap_d = overlap_q;
        o_d       = 1'b0;
        hit       = 1'b0;
        word      = {hist_q, i};

        if (cfg_load) begin
            pattern_d = cfg_pattern;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
        end else if (i_valid) begin
            // A zeroed history must not match until LEN real bits have arrived.
            hit = (fill_q == FILL_MAX) && (word == pattern_q);
            if (hit) begin
                o_d = 1'b1;
                if (overlap_q) begin
                    hist_d = word[LEN-2:0];
                end else begin
                    hist_d = '0;
                    fill_d = '0;
                end
            end else begin
                hist_d = word[LEN-2:0];
                fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + FILL_W'(1);
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (cnt_clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + COUNT_W'(1);
            if (cnt_q == CNT_MAX - COUNT_W'(1)) begin
                sat_d = 1'b1;
            end
        end
    end

    assign o         = o_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param
// LEN=4, COUNT_W=4; a behavioural bit-history model feeds an expected-result queue.
module tb_seq_detector_param;

    localparam int LEN     = 4;
    localparam int COUNT_W = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i = 1'b0;
    logic               i_valid = 1'b0;
    logic               cfg_load = 1'b0;
    logic [LEN-1:0]     cfg_pattern = '0;
    logic               cfg_overlap = 1'b0;
    logic               cnt_clr = 1'b0;
    logic               o;
    logic [COUNT_W-1:0] match_cnt;
    logic               cnt_sat;

    seq_detector_param #(.LEN(LEN), .COUNT_W(COUNT_W), .RESET_PATTERN(4'b1011)) dut (
        .clk(clk), .rst_n(rst_n), .i(i), .i_valid(i_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .o(o), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       o;
        logic [3:0] cnt;
        logic       sat;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    // reference model: raw bit history plus count of bits seen since last clear
    logic [31:0] m_shift;
    int          m_nbits;
    logic [3:0]  m_pat;
    logic        m_ovl;
    int          m_cnt;
    logic        m_sat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic model_reset();
        m_shift = '0; m_nbits = 0; m_pat = 4'b1011; m_ovl = 1'b1; m_cnt = 0; m_sat = 1'b0;
    endtask

    task automatic step(input logic v, input logic b, input logic ld,
                        input logic [3:0] lpat, input logic lovl, input logic clr);
        logic mo;
        exp_t e;
        exp_t got;
        @(negedge clk);
        i_valid = v; i = b; cfg_load = ld; cfg_pattern = lpat; cfg_overlap = lovl; cnt_clr = clr;
        mo = 1'b0;
        if (ld) begin
            m_pat = lpat; m_ovl = lovl; m_shift = '0; m_nbits = 0;
        end else if (v) begin
            m_shift = {m_shift[30:0], b};
            m_nbits++;
            mo = (m_nbits >= LEN) && (m_shift[3:0] == m_pat);
            if (mo && !m_ovl) m_nbits = 0;
        end
        if (clr) begin
            m_cnt = 0; m_sat = 1'b0;
        end else if (mo && m_cnt < 15) begin
            m_cnt++;
            if (m_cnt == 15) m_sat = 1'b1;
        end
        e.o = mo; e.cnt = 4'(m_cnt); e.sat = m_sat;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        if (o) pulses++;
        check("o", {31'b0, o}, {31'b0, got.o});
        check("match_cnt", {28'b0, match_cnt}, {28'b0, got.cnt});
        check("cnt_sat", {31'b0, cnt_sat}, {31'b0, got.sat});
        i_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic send(input logic b);
        step(1'b1, b, 1'b0, 4'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [3:0] p, input logic ovl);
        step(1'b0, 1'b0, 1'b1, p, ovl, 1'b0);
    endtask

    task automatic send_vec(input logic [31:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) send(bits[k]);
    endtask

    initial begin
        model_reset();
        #12;
        check("reset_o", {31'b0, o}, 32'd0);
        check("reset_cnt", {28'b0, match_cnt}, 32'd0);
        check("reset_sat", {31'b0, cnt_sat}, 32'd0);
        rst_n = 1'b1;

        // default pattern 1011, overlap
        pulses = 0;
        send_vec(32'b1011011, 7);
        check("t1_pulses", pulses, 2);
        check("t1_cnt", {28'b0, match_cnt}, 32'd2);

        // non-overlapping
        load(4'b1011, 1'b0);
        pulses = 0;
        send_vec(32'b1011011, 7);
        check("t2_pulses", pulses, 1);

        // all-zero pattern must respect fill
        load(4'b0000, 1'b1);
        pulses = 0;
        send_vec(32'b0, 5);
        check("t3_ovl_pulses", pulses, 2);
        load(4'b0000, 1'b0);
        pulses = 0;
        send_vec(32'b0, 8);
        check("t3_novl_pulses", pulses, 2);

        // invalid bits ignored
        load(4'b1011, 1'b1);
        pulses = 0;
        send(1'b1); send(1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, k[0], 1'b0, 4'b0, 1'b0, 1'b0);
        send(1'b1); send(1'b1);
        check("t4_pulses", pulses, 1);

        // saturation with all-ones pattern
        step(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        load(4'b1111, 1'b1);
        pulses = 0;
        send_vec(32'hFFFFF, 20);
        check("t5_pulses", pulses, 17);
        check("t5_cnt", {28'b0, match_cnt}, 32'd15);
        check("t5_sat", {31'b0, cnt_sat}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        check("t5_clr_cnt", {28'b0, match_cnt}, 32'd0);

        // clear coinciding with a match: pulse but no count
        send(1'b1);
        step(1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1);

        // asynchronous reset drops o between edges
        send(1'b1);
        check("t6_o_before", {31'b0, o}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_async_o", {31'b0, o}, 32'd0);
        check("t6_async_cnt", {28'b0, match_cnt}, 32'd0);
        #1 rst_n = 1'b1;

        // reset mid-pattern
        send(1'b1); send(1'b0); send(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
        pulses = 0;
        send(1'b1);
        check("t7_no_match", pulses, 0);

        // load coinciding with final bit discards it
        send(1'b1); send(1'b0); send(1'b1);
        step(1'b1, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b0);
        send_vec(32'b011, 3);
        send_vec(32'b1011, 4);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
